// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//
// Shared definitions for the pipeline hazard controller:
//   - default MDU latency and statistics counter width
//   - FSM state enumeration (encoding is visible on the top-level state port)
//   - packed bundle of stage register enables / flushes plus the handful of
//     fixed patterns the controller ever drives
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int unsigned MduLatDefault = 32;
    localparam int unsigned CntWDefault   = 16;

    typedef enum logic [2:0] {
        StRun      = 3'd0,
        StMemWait  = 3'd1,
        StLdStall  = 3'd2,
        StMduStall = 3'd3,
        StBrFlush  = 3'd4
    } pipe_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } stage_ctrl_t;

    // Every stage advances, no bubbles.
    localparam stage_ctrl_t CtrlFlow   = 7'b11111_00;
    // Whole pipeline frozen while the data memory holds MEM.
    localparam stage_ctrl_t CtrlFreeze = 7'b00000_00;
    // Front end held, bubble into ID/EX, back end keeps draining.
    localparam stage_ctrl_t CtrlBubble = 7'b00111_01;
    // Fetch redirects, the wrong-path slot in IF/ID is killed.
    localparam stage_ctrl_t CtrlBrKill = 7'b11111_10;
    // Held in reset: nothing advances, both bubble registers forced.
    localparam stage_ctrl_t CtrlReset  = 7'b00000_11;

endpackage

// File: rtl/mdu_timer.sv
// ---------------------------------------------------------------------------
// mdu_timer
//
// Countdown tracking one in-flight multiply/divide operation.
//
// Ports
//   clk    in   clock, state changes on rising edge
//   rst_n  in   asynchronous active-low reset, aborts any operation
//   start  in   operation issued this cycle; (re)loads the count to LAT-1
//   busy   out  operation in flight (from the cycle after start)
//   done   out  high on the last busy cycle; busy drops on the next cycle
//
// With start in cycle c the unit is busy in cycles c+1 .. c+LAT-1 and done
// pulses in cycle c+LAT-1, so the operation occupies LAT cycles counting the
// issue cycle.
// ---------------------------------------------------------------------------
module mdu_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LAT = MduLatDefault
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int unsigned TimerW = $clog2(LAT);

    logic [TimerW-1:0] timer_q, timer_d;
    logic              busy_q, busy_d;

    // The count reaches zero at the end of the cycle in which it reads one,
    // so that cycle is the last one of the operation.
    assign done = busy_q && (timer_q == TimerW'(1));
    assign busy = busy_q;

    always_comb begin
        timer_d = timer_q;
        busy_d  = busy_q;
        if (start) begin
            // A start while busy simply restarts the operation.
            timer_d = TimerW'(LAT - 1);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            timer_d = timer_q - TimerW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Stall / flush controller for a five-stage pipeline. Resolves data-memory
// wait states, HI/LO dependencies on an in-flight multiply/divide, load-use
// hazards and taken branches into stage register enables and bubble inserts,
// and keeps saturating statistics of stalled and flushed cycles.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   ld_hazard            ID source matches the EX load destination
//   br_taken             branch resolved taken in ID
//   mdu_start            mult/div issued from EX this cycle
//   mdu_dep              ID instruction reads HI/LO
//   dmem_req, dmem_ready MEM access active / completing this cycle
//   pc_en .. memwb_en    stage register enables
//   ifid_flush           bubble into IF/ID
//   idex_flush           bubble into ID/EX
//   mdu_busy, mdu_done   MDU in flight / last MDU cycle
//   state                current FSM state encoding
//   stall_cnt            cycles with pc_en low (saturating)
//   flush_cnt            cycles with any flush high (saturating)
//
// Enables and flushes are combinational from the state and the inputs.
// Priority, highest first: memory wait, MDU dependency, load-use, branch.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LAT = MduLatDefault,
    parameter int unsigned CNT_W   = CntWDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_hazard,
    input  logic             br_taken,
    input  logic             mdu_start,
    input  logic             mdu_dep,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_e       state_q, state_d;
    stage_ctrl_t       ctrl;
    logic              mem_wait;
    logic              mdu_hold;
    logic              ld_mask, br_mask;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // -----------------------------------------------------------------------
    // MDU countdown
    // -----------------------------------------------------------------------
    mdu_timer #(
        .LAT (MDU_LAT)
    ) u_mdu_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mdu_start),
        .busy  (mdu_busy),
        .done  (mdu_done)
    );

    // -----------------------------------------------------------------------
    // Hazard FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mem_wait = dmem_req && !dmem_ready;
        mdu_hold = mdu_busy && mdu_dep;

        // The cycle after a bubble the hazard unit still sees the same load,
        // and the cycle after a taken branch ID holds the killed slot; both
        // requests are stale and must not act again.
        ld_mask = 1'b0;
        br_mask = 1'b0;
        case (state_q)
            StLdStall: ld_mask = 1'b1;
            StBrFlush: br_mask = 1'b1;
            default:   ;
        endcase

        ctrl    = CtrlFlow;
        state_d = StRun;

        if (!rst_n) begin
            ctrl    = CtrlReset;
            state_d = StRun;
        end else if (mem_wait) begin
            ctrl    = CtrlFreeze;
            state_d = StMemWait;
        end else if (mdu_hold) begin
            // Held every cycle until busy drops, i.e. the cycle after done.
            ctrl    = CtrlBubble;
            state_d = StMduStall;
        end else if (ld_hazard && !ld_mask) begin
            ctrl    = CtrlBubble;
            state_d = StLdStall;
        end else if (br_taken && !br_mask) begin
            ctrl    = CtrlBrKill;
            state_d = StBrFlush;
        end
        // A MEM_WAIT cycle with dmem_ready falls through to the normal
        // priority chain, so a hazard pending behind the wait acts at once.
    end

    assign pc_en      = ctrl.pc_en;
    assign ifid_en    = ctrl.ifid_en;
    assign idex_en    = ctrl.idex_en;
    assign exmem_en   = ctrl.exmem_en;
    assign memwb_en   = ctrl.memwb_en;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign state      = state_q;

    // -----------------------------------------------------------------------
    // Saturating statistics
    // -----------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((ifid_flush || idex_flush) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Two controllers share one stimulus stream: the default build and a build
// with 4-bit counters. Each cycle the stimulus process predicts the outputs
// from a cycle-numbered reference model and queues them; the monitor pops
// one entry per falling edge and compares. Directed scenarios additionally
// attach fixed expected bits/counts to their entries.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int LAT = 32;

    typedef struct packed {
        logic [4:0] en;   // pc, ifid, idex, exmem, memwb
        logic [1:0] fl;   // ifid_flush, idex_flush
        logic       busy;
        logic       done;
        logic [2:0] st;
    } ctl_t;

    typedef struct {
        ctl_t ctl;
        int   stall;
        int   flush;
        ctl_t sm;         // directed mask (0 = none)
        ctl_t sv;         // directed value under mask
        int   ss;         // directed stall_cnt, -1 = none
        int   sf;         // directed flush_cnt, -1 = none
        int   s4;         // directed 4-bit stall_cnt, -1 = none
    } exp_t;

    logic clk, rst_n;
    logic ld_hazard, br_taken, mdu_start, mdu_dep, dmem_req, dmem_ready;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic        mdu_busy, mdu_done;
    logic [2:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_flush4, idex_flush4;
    logic        mdu_busy4, mdu_done4;
    logic [2:0]  state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ld_hazard(ld_hazard), .br_taken(br_taken),
        .mdu_start(mdu_start), .mdu_dep(mdu_dep), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ld_hazard(ld_hazard), .br_taken(br_taken),
        .mdu_start(mdu_start), .mdu_dep(mdu_dep), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4),
        .exmem_en(exmem_en4), .memwb_en(memwb_en4), .ifid_flush(ifid_flush4),
        .idex_flush(idex_flush4), .mdu_busy(mdu_busy4), .mdu_done(mdu_done4),
        .state(state4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;

    // Reference model: cycle numbers instead of a countdown register.
    int   cyc = 0;
    int   m_state = 0;       // 0 run, 1 mem, 2 ld, 3 mdu, 4 br
    int   m_start = 0;
    int   m_end = -1;        // last busy cycle of the MDU op
    int   n_stall = 0;
    int   n_flush = 0;

    // Directed annotations for the next driven cycle.
    ctl_t sp_m, sp_v;
    int   sp_ss = -1, sp_sf = -1, sp_s4 = -1;

    task automatic clear_spec();
        sp_m = '0; sp_v = '0; sp_ss = -1; sp_sf = -1; sp_s4 = -1;
    endtask

    task automatic drive(input bit rst, input bit ld, input bit br, input bit ms,
                         input bit md, input bit dq, input bit dy);
        exp_t e;
        bit busy, done, memw, mdus, ldh, brh, stall_fe;
        int cause;
        @(posedge clk);
        #1;
        rst_n = !rst; ld_hazard = ld; br_taken = br; mdu_start = ms;
        mdu_dep = md; dmem_req = dq; dmem_ready = dy;
        if (rst) begin
            e.ctl = '0;
            e.ctl.fl = 2'b11;
            e.stall = 0; e.flush = 0;
            m_state = 0; m_start = 0; m_end = -1; n_stall = 0; n_flush = 0;
        end else begin
            busy  = (cyc > m_start) && (cyc <= m_end);
            done  = busy && (cyc == m_end);
            memw  = dq && !dy;
            mdus  = busy && md;
            ldh   = ld && (m_state != 2);
            brh   = br && (m_state != 4);
            cause = memw ? 1 : mdus ? 3 : ldh ? 2 : brh ? 4 : 0;
            stall_fe = (cause == 1) || (cause == 2) || (cause == 3);
            e.ctl.en   = {!stall_fe, !stall_fe, !memw, !memw, !memw};
            e.ctl.fl   = {cause == 4, (cause == 2) || (cause == 3)};
            e.ctl.busy = busy;
            e.ctl.done = done;
            e.ctl.st   = 3'(m_state);
            e.stall = n_stall;
            e.flush = n_flush;
            if (stall_fe) n_stall++;
            if (e.ctl.fl != 2'b00) n_flush++;
            m_state = cause;
            if (ms) begin
                m_start = cyc;
                m_end   = cyc + LAT - 1;
            end
        end
        cyc++;
        e.sm = sp_m; e.sv = sp_v & sp_m; e.ss = sp_ss; e.sf = sp_sf; e.s4 = sp_s4;
        sb_q.push_back(e);
        clear_spec();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin : stimulus
        rst_n = 1'b0; ld_hazard = 0; br_taken = 0; mdu_start = 0;
        mdu_dep = 0; dmem_req = 0; dmem_ready = 0;
        clear_spec();
        do_reset(3);

        // Load-use held two cycles: one bubble only.
        idle(2);
        sp_m.en[4] = 1; sp_m.fl[0] = 1; sp_v.en[4] = 0; sp_v.fl[0] = 1;
        drive(0, 1, 0, 0, 0, 0, 0);
        sp_m.en[4] = 1; sp_m.fl[0] = 1; sp_v.en[4] = 1; sp_v.fl[0] = 0;
        drive(0, 1, 0, 0, 0, 0, 0);
        sp_ss = 1;
        idle(2);

        // Branch in cycles 5 and 6 after reset: one kill only.
        do_reset(2);
        idle(5);
        sp_m.fl[1] = 1; sp_v.fl[1] = 1;
        drive(0, 0, 1, 0, 0, 0, 0);
        sp_m.fl[1] = 1; sp_v.fl[1] = 0;
        drive(0, 0, 1, 0, 0, 0, 0);
        sp_sf = 1;
        idle(2);

        // Memory wait over a pending load-use.
        do_reset(2);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            sp_m.en = 5'b11111; sp_v.en = 5'b00000;
            drive(0, 1, 0, 0, 0, 1, 0);
        end
        sp_m.en = 5'b11111; sp_m.fl[0] = 1; sp_v.en = 5'b00111; sp_v.fl[0] = 1;
        drive(0, 1, 0, 0, 0, 1, 1);
        idle(2);

        // MDU: start in cycle 10, dependency from cycle 11.
        do_reset(2);
        idle(10);
        drive(0, 0, 0, 1, 0, 0, 0);
        for (int c = 11; c <= 45; c++) begin
            sp_m.en[4] = 1; sp_m.done = 1;
            sp_v.en[4] = (c >= 42); sp_v.done = (c == 41);
            drive(0, 0, 0, 0, 1, 0, 0);
        end
        idle(2);

        // Twenty frozen cycles: 4-bit counter sticks at 15.
        do_reset(2);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 1, 0);
        sp_ss = 20; sp_s4 = 15;
        idle(2);

        // Reset while the MDU count reads 5: no late done pulse.
        do_reset(2);
        drive(0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 26; i++) drive(0, 0, 0, 0, 1, 0, 0);
        sp_m.busy = 1; sp_v.busy = 0; sp_ss = 0; sp_sf = 0; sp_s4 = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            sp_m.busy = 1; sp_m.done = 1; sp_v.busy = 0; sp_v.done = 0;
            drive(0, 0, 0, 0, 1, 0, 0);
        end

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit dq;
            dq = ($urandom_range(99) < 30);
            drive(($urandom_range(299) == 0),
                  ($urandom_range(99) < 20),
                  ($urandom_range(99) < 15),
                  ($urandom_range(99) < 5),
                  ($urandom_range(99) < 40),
                  dq,
                  dq ? ($urandom_range(1) == 1) : ($urandom_range(1) == 1));
        end
        idle(2);
        stim_done = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        ctl_t a, a4;
        int   idle_cnt;
        idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (stim_done && sb_q.size() == 0) break;
            if (sb_q.size() == 0) begin
                idle_cnt++;
                if (idle_cnt > 50) begin
                    total++; bad++;
                    $display("FAIL sb_timeout: queue empty act=0 req=entries");
                    break;
                end
                continue;
            end
            idle_cnt = 0;
            e  = sb_q.pop_front();
            a  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                  mdu_busy, mdu_done, state};
            a4 = {pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4, ifid_flush4,
                  idex_flush4, mdu_busy4, mdu_done4, state4};

            total++;
            if (a !== e.ctl || a4 !== e.ctl) begin
                bad++;
                $display("FAIL ctl t=%0t act=%h act4=%h req=%h", $time, a, a4, e.ctl);
            end

            total++;
            if (stall_cnt !== 16'(e.stall) || flush_cnt !== 16'(e.flush) ||
                stall_cnt4 !== 4'((e.stall > 15) ? 15 : e.stall) ||
                flush_cnt4 !== 4'((e.flush > 15) ? 15 : e.flush)) begin
                bad++;
                $display("FAIL cnt t=%0t act=%0d/%0d act4=%0d/%0d req=%0d/%0d",
                         $time, stall_cnt, flush_cnt, stall_cnt4, flush_cnt4,
                         e.stall, e.flush);
            end

            if (e.sm != '0) begin
                total++;
                if ((a & e.sm) !== e.sv) begin
                    bad++;
                    $display("FAIL spec_ctl t=%0t act=%h req=%h mask=%h",
                             $time, a & e.sm, e.sv, e.sm);
                end
            end
            if (e.ss >= 0) begin
                total++;
                if (stall_cnt !== 16'(e.ss)) begin
                    bad++;
                    $display("FAIL spec_stall t=%0t act=%0d req=%0d", $time, stall_cnt, e.ss);
                end
            end
            if (e.sf >= 0) begin
                total++;
                if (flush_cnt !== 16'(e.sf)) begin
                    bad++;
                    $display("FAIL spec_flush t=%0t act=%0d req=%0d", $time, flush_cnt, e.sf);
                end
            end
            if (e.s4 >= 0) begin
                total++;
                if (stall_cnt4 !== 4'(e.s4)) begin
                    bad++;
                    $display("FAIL spec_sat t=%0t act=%0d req=%0d", $time, stall_cnt4, e.s4);
                end
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: act=running req=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 32, giving multiply/divide unit latency in cycles (legal range 2..63).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the stall and flush statistics counters.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ld_hazard  input  1  load-use hazard from hazard detection (ID source matches EXE load destination).
REQ-006 br_taken  input  1  branch resolved taken in ID.
REQ-007 mdu_start  input  1  mult/div issued from EX this cycle.
REQ-008 mdu_dep  input  1  ID instruction reads HI/LO.
REQ-009 dmem_req  input  1  MEM stage has an active data access.
REQ-010 dmem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage register enables.
REQ-012 ifid_flush, idex_flush  output  1 each  insert a bubble into IF/ID or ID/EX.
REQ-013 mdu_busy  output  1  MDU operation in flight.
REQ-014 mdu_done  output  1  one-cycle pulse on the last MDU cycle.
REQ-015 state  output  3  current FSM state encoding.
REQ-016 stall_cnt, flush_cnt  output  CNT_W each  saturating statistics counters.

Function
REQ-017 SHALL implement FSM states RUN=0, MEM_WAIT=1, LD_STALL=2, MDU_STALL=3, BR_FLUSH=4; stage enables and flushes are combinational from state and inputs.
REQ-018 Priority when several conditions hold in the same cycle, highest first: memory wait (dmem_req && !dmem_ready), MDU dependency (mdu_busy && mdu_dep), ld_hazard, br_taken.
REQ-019 Memory wait SHALL drive all five enables 0 and both flushes 0, and set next state MEM_WAIT.
REQ-020 The FSM SHALL remain in MEM_WAIT until the cycle dmem_ready=1, then return to RUN.
REQ-021 The MDU timer SHALL keep counting during MEM_WAIT.
REQ-022 MDU dependency SHALL drive pc_en=0, ifid_en=0 and idex_flush=1, keep the back-end enables at 1, and set next state MDU_STALL.
REQ-023 The stall SHALL release on the cycle after mdu_done.
REQ-024 ld_hazard SHALL drive pc_en=0, ifid_en=0 and idex_flush=1 for exactly one cycle, with next state LD_STALL.
REQ-025 In LD_STALL, ld_hazard SHALL be ignored, so back-to-back assertion yields one bubble only.
REQ-026 br_taken SHALL drive ifid_flush=1 with pc_en=1 and set next state BR_FLUSH.
REQ-027 A br_taken received while in BR_FLUSH SHALL be ignored, since it comes from the flushed slot.
REQ-028 With no condition active, all enables SHALL be 1, both flushes 0, and next state RUN.
REQ-029 mdu_start SHALL load the timer with MDU_LAT-1 and set mdu_busy=1.
REQ-030 The timer SHALL decrement each cycle, and mdu_done SHALL pulse when the timer reaches 0, with mdu_busy clearing the next cycle.
REQ-031 mdu_start while mdu_busy=1 SHALL reload the timer (restart).
REQ-032 stall_cnt SHALL increment each cycle pc_en=0, and flush_cnt SHALL increment each cycle ifid_flush or idex_flush is 1.
REQ-033 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-034 While rst_n=0: state=RUN, timer=0, mdu_busy=0, mdu_done=0, and both counters 0.
REQ-035 While rst_n=0: all enables 0 and both flushes 1.
REQ-036 Reset asserted mid-operation SHALL abort any MEM_WAIT or MDU operation immediately.
REQ-037 The first cycle after rst_n rises SHALL behave as RUN.

Structure
REQ-038 Package pipe_ctrl_pkg SHALL hold the state enumeration and default MDU_LAT and CNT_W constants.
REQ-039 A sub-module mdu_timer (inputs start, clk, rst_n; outputs busy, done) SHALL implement the MDU countdown.
REQ-040 The counters and FSM SHALL live in the top level.

Verification
REQ-041 Load-use: ld_hazard=1 for 2 consecutive cycles -> exactly one cycle with pc_en=0 and idex_flush=1; stall_cnt=1.
REQ-042 Branch: br_taken=1 in cycles 5 and 6 -> ifid_flush=1 in cycle 5 only; flush_cnt=1.
REQ-043 Memory wait: dmem_req=1 with dmem_ready=0 for 3 cycles while ld_hazard=1 -> all enables 0 for 3 cycles; LD_STALL bubble issues after dmem_ready=1.
REQ-044 MDU: mdu_start at cycle 10 with MDU_LAT=32 and mdu_dep=1 from cycle 11 -> mdu_done at cycle 41; pc_en=0 for cycles 11-41; pc_en=1 at cycle 42.
REQ-045 Saturation with CNT_W=4: hold a stall for 20 cycles -> stall_cnt sticks at 15.
REQ-046 Reset mid-MDU: rst_n=0 at timer=5 -> mdu_busy=0 and counters 0 asynchronously; no mdu_done pulse after release.
